rggen_apb_adapter_sync: RTL and testbench

RGGEN_APB_ADAPTER_SYNC -- requirements
Module: rggen_apb_adapter_sync

---
 rtl/rggen_apb_adapter_sync_pkg.sv | 24 ++
 rtl/rggen_adapter_common_sync.sv | 124 ++++++++++++
 rtl/rggen_apb_adapter_sync.sv | 79 +++++++
 tb/tb_rggen_apb_adapter_sync.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_apb_adapter_sync_pkg.sv
// Shared rggen access/status codes, adapter FSM encodings and the APB error mapping.
// Constants and a pure function only; no timing or flow control of its own.
`ifndef RGGEN_RTL_MACROS
`define RGGEN_RTL_MACROS
`define RGGEN_READ          2'b10
`define RGGEN_WRITE         2'b11
`define RGGEN_OKAY          2'b00
`define RGGEN_EXOKAY        2'b01
`define RGGEN_SLAVE_ERROR   2'b10
`define RGGEN_DECODE_ERROR  2'b11
`endif

package rggen_apb_adapter_sync_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQUEST = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    // A decode error is only reported as an error when the block is built to do so.
    function automatic logic pslverr_of(input logic [1:0] status, input bit error_status);
        return status[1] && (error_status || (status != `RGGEN_DECODE_ERROR));
    endfunction

endpackage

// File: rtl/rggen_adapter_common_sync.sv
// Protocol-independent register access engine: capture, decode, FSM and response mux.
// Setup-to-response 3 cycles minimum, +1 per cycle of downstream ready delay; aborted responses are dropped.
module rggen_adapter_common_sync
    import rggen_apb_adapter_sync_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH       = 8,
    parameter int                       LOCAL_ADDRESS_WIDTH = 8,
    parameter int                       BUS_WIDTH           = 32,
    parameter int                       REGISTERS           = 1,
    parameter bit                       PRE_DECODE          = 1'b0,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
    parameter int                       BYTE_SIZE           = 256,
    parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0
)(
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_bus_valid,
    input  logic                             i_bus_select,
    input  logic                             i_bus_write,
    input  logic [ADDRESS_WIDTH-1:0]         i_bus_address,
    input  logic [BUS_WIDTH-1:0]             i_bus_write_data,
    input  logic [BUS_WIDTH/8-1:0]           i_bus_strobe,
    output logic                             o_bus_ready,
    output logic [1:0]                       o_bus_status,
    output logic [BUS_WIDTH-1:0]             o_bus_read_data,
    output logic                             o_register_valid,
    output logic [1:0]                       o_register_access,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]   o_register_address,
    output logic [BUS_WIDTH-1:0]             o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]           o_register_strobe,
    input  logic [REGISTERS-1:0]             i_register_active,
    input  logic [REGISTERS-1:0]             i_register_ready,
    input  logic [2*REGISTERS-1:0]           i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0]   i_register_read_data
);

    localparam int LSB = $clog2(BUS_WIDTH / 8);
    localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ADDR_MASK = ~LOCAL_ADDRESS_WIDTH'((1 << LSB) - 1);
    localparam logic [ADDRESS_WIDTH:0] RANGE_LO = {1'b0, BASE_ADDRESS};
    localparam logic [ADDRESS_WIDTH:0] RANGE_HI = RANGE_LO + (ADDRESS_WIDTH+1)'(BYTE_SIZE - 1);

    logic [1:0]           state;
    logic                 done;
    logic                 in_range;
    logic                 is_write;
    logic                 respond;
    logic [ADDRESS_WIDTH:0] addr_ext;
    logic [1:0]           mux_status;
    logic [BUS_WIDTH-1:0] mux_data;
    logic [1:0]           resp_status;
    logic [BUS_WIDTH-1:0] resp_data;

    assign addr_ext = {1'b0, i_bus_address};
    assign in_range = !PRE_DECODE || ((addr_ext >= RANGE_LO) && (addr_ext <= RANGE_HI));
    assign is_write = (o_register_access == `RGGEN_WRITE);

    always_comb begin
        mux_status = '0;
        mux_data   = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (i_register_ready[i]) begin
                mux_status = mux_status | i_register_status[2*i +: 2];
                mux_data   = mux_data | i_register_read_data[BUS_WIDTH*i +: BUS_WIDTH];
            end
        end
    end

    // The response is latched in the ready cycle and presented after one settling cycle in REQUEST.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                 <= IDLE;
            done                  <= 1'b0;
            o_register_valid      <= 1'b0;
            o_register_access     <= '0;
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
            resp_status           <= '0;
            resp_data             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_bus_valid) begin
                        state                 <= REQUEST;
                        done                  <= 1'b0;
                        o_register_valid      <= in_range;
                        o_register_access     <= i_bus_write ? `RGGEN_WRITE : `RGGEN_READ;
                        o_register_address    <= i_bus_address[LOCAL_ADDRESS_WIDTH-1:0] & ADDR_MASK;
                        o_register_write_data <= i_bus_write ? i_bus_write_data : '0;
                        o_register_strobe     <= i_bus_write ? i_bus_strobe : '1;
                    end
                end
                REQUEST: begin
                    if (done) begin
                        state <= RESPOND;
                    end else if (!o_register_valid) begin
                        done        <= 1'b1;
                        resp_status <= `RGGEN_DECODE_ERROR;
                        resp_data   <= is_write ? '0 : DEFAULT_READ_DATA;
                    end else if (|i_register_ready) begin
                        done             <= 1'b1;
                        o_register_valid <= 1'b0;
                        resp_status      <= mux_status;
                        resp_data        <= is_write ? '0 : mux_data;
                    end else if (~|i_register_active) begin
                        done             <= 1'b1;
                        o_register_valid <= 1'b0;
                        resp_status      <= `RGGEN_DECODE_ERROR;
                        resp_data        <= is_write ? '0 : DEFAULT_READ_DATA;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A deselected master in RESPOND has abandoned the transfer; nothing is presented.
    assign respond         = (state == RESPOND) && i_bus_select;
    assign o_bus_ready     = respond;
    assign o_bus_status    = respond ? resp_status : 2'b00;
    assign o_bus_read_data = respond ? resp_data : '0;

endmodule

// File: rtl/rggen_apb_adapter_sync.sv
// APB slave front end for rggen register blocks; maps setup/access phases onto the common engine.
// pready 3 cycles after setup minimum, stretched while register ready is pending; pready drops if psel does.
module rggen_apb_adapter_sync
    import rggen_apb_adapter_sync_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH       = 8,
    parameter int                       LOCAL_ADDRESS_WIDTH = 8,
    parameter int                       BUS_WIDTH           = 32,
    parameter int                       REGISTERS           = 1,
    parameter bit                       PRE_DECODE          = 1'b0,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
    parameter int                       BYTE_SIZE           = 256,
    parameter bit                       ERROR_STATUS        = 1'b0,
    parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0
)(
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_psel,
    input  logic                             i_penable,
    input  logic [ADDRESS_WIDTH-1:0]         i_paddr,
    input  logic [2:0]                       i_pprot,
    input  logic                             i_pwrite,
    input  logic [BUS_WIDTH/8-1:0]           i_pstrb,
    input  logic [BUS_WIDTH-1:0]             i_pwdata,
    output logic                             o_pready,
    output logic [BUS_WIDTH-1:0]             o_prdata,
    output logic                             o_pslverr,
    output logic                             o_register_valid,
    output logic [1:0]                       o_register_access,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]   o_register_address,
    output logic [BUS_WIDTH-1:0]             o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]           o_register_strobe,
    input  logic [REGISTERS-1:0]             i_register_active,
    input  logic [REGISTERS-1:0]             i_register_ready,
    input  logic [2*REGISTERS-1:0]           i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0]   i_register_read_data
);

    logic [1:0] bus_status;
    logic       unused_pprot;

    // Protection attributes carry no meaning for register access.
    assign unused_pprot = ^i_pprot;

    rggen_adapter_common_sync #(
        .ADDRESS_WIDTH       (ADDRESS_WIDTH),
        .LOCAL_ADDRESS_WIDTH (LOCAL_ADDRESS_WIDTH),
        .BUS_WIDTH           (BUS_WIDTH),
        .REGISTERS           (REGISTERS),
        .PRE_DECODE          (PRE_DECODE),
        .BASE_ADDRESS        (BASE_ADDRESS),
        .BYTE_SIZE           (BYTE_SIZE),
        .DEFAULT_READ_DATA   (DEFAULT_READ_DATA)
    ) u_common (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .i_bus_valid           (i_psel && !i_penable),
        .i_bus_select          (i_psel),
        .i_bus_write           (i_pwrite),
        .i_bus_address         (i_paddr),
        .i_bus_write_data      (i_pwdata),
        .i_bus_strobe          (i_pstrb),
        .o_bus_ready           (o_pready),
        .o_bus_status          (bus_status),
        .o_bus_read_data       (o_prdata),
        .o_register_valid      (o_register_valid),
        .o_register_access     (o_register_access),
        .o_register_address    (o_register_address),
        .o_register_write_data (o_register_write_data),
        .o_register_strobe     (o_register_strobe),
        .i_register_active     (i_register_active),
        .i_register_ready      (i_register_ready),
        .i_register_status     (i_register_status),
        .i_register_read_data  (i_register_read_data)
    );

    assign o_pslverr = pslverr_of(bus_status, ERROR_STATUS);

endmodule

// File: tb/tb_rggen_apb_adapter_sync.sv
// Directed bench: two adapters share one APB master and one register model.
// dut_a decodes 0x100..0x13F with error reporting on; dut_b has no pre-decode and ERROR_STATUS off.
module tb_rggen_apb_adapter_sync;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic [15:0] paddr;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [1:0]  reg_active;
    logic [1:0]  reg_ready;
    logic [3:0]  reg_status;
    logic [63:0] reg_rdata;

    logic        a_pready, a_pslverr, a_valid;
    logic [31:0] a_prdata, a_wdata;
    logic [1:0]  a_access;
    logic [7:0]  a_address;
    logic [3:0]  a_strobe;
    logic        b_pready, b_pslverr, b_valid;
    logic [31:0] b_prdata, b_wdata;
    logic [1:0]  b_access;
    logic [7:0]  b_address;
    logic [3:0]  b_strobe;

    int tests  = 0;
    int failed = 0;

    rggen_apb_adapter_sync #(
        .ADDRESS_WIDTH (16), .LOCAL_ADDRESS_WIDTH (8), .BUS_WIDTH (32), .REGISTERS (2),
        .PRE_DECODE (1'b1), .BASE_ADDRESS (16'h0100), .BYTE_SIZE (32'h40),
        .ERROR_STATUS (1'b1), .DEFAULT_READ_DATA (32'h0000_0BAD)
    ) dut_a (
        .i_clk (clk), .i_rst (rst), .i_psel (psel), .i_penable (penable), .i_paddr (paddr),
        .i_pprot (pprot), .i_pwrite (pwrite), .i_pstrb (pstrb), .i_pwdata (pwdata),
        .o_pready (a_pready), .o_prdata (a_prdata), .o_pslverr (a_pslverr),
        .o_register_valid (a_valid), .o_register_access (a_access), .o_register_address (a_address),
        .o_register_write_data (a_wdata), .o_register_strobe (a_strobe),
        .i_register_active (reg_active), .i_register_ready (reg_ready),
        .i_register_status (reg_status), .i_register_read_data (reg_rdata)
    );

    rggen_apb_adapter_sync #(
        .ADDRESS_WIDTH (16), .LOCAL_ADDRESS_WIDTH (8), .BUS_WIDTH (32), .REGISTERS (2),
        .PRE_DECODE (1'b0), .BASE_ADDRESS (16'h0000), .BYTE_SIZE (256),
        .ERROR_STATUS (1'b0), .DEFAULT_READ_DATA (32'h0000_0BAD)
    ) dut_b (
        .i_clk (clk), .i_rst (rst), .i_psel (psel), .i_penable (penable), .i_paddr (paddr),
        .i_pprot (pprot), .i_pwrite (pwrite), .i_pstrb (pstrb), .i_pwdata (pwdata),
        .o_pready (b_pready), .o_prdata (b_prdata), .o_pslverr (b_pslverr),
        .o_register_valid (b_valid), .o_register_access (b_access), .o_register_address (b_address),
        .o_register_write_data (b_wdata), .o_register_strobe (b_strobe),
        .i_register_active (reg_active), .i_register_ready (reg_ready),
        .i_register_status (reg_status), .i_register_read_data (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic regs(input logic [1:0] act, input logic [1:0] rdy, input logic [3:0] st,
                        input logic [63:0] rd);
        reg_active = act;
        reg_ready  = rdy;
        reg_status = st;
        reg_rdata  = rd;
    endtask

    task automatic setup(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] sb);
        tick();
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = sb;
    endtask

    task automatic release_bus();
        tick();
        psel = 1'b0; penable = 1'b0;
        regs(2'b00, 2'b00, 4'h0, 64'h0);
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; pprot = 3'b010;
        pwrite = 1'b0; pstrb = '0; pwdata = '0;
        regs(2'b00, 2'b00, 4'h0, 64'h0);
        tick(); tick();
        @(negedge clk);
        check("rst_valid",   64'(a_valid),   64'd0);
        check("rst_access",  64'(a_access),  64'd0);
        check("rst_address", 64'(a_address), 64'd0);
        check("rst_wdata",   64'(a_wdata),   64'd0);
        check("rst_strobe",  64'(a_strobe),  64'd0);
        check("rst_pready",  64'(a_pready),  64'd0);
        check("rst_prdata",  64'(a_prdata),  64'd0);
        check("rst_pslverr", 64'(a_pslverr), 64'd0);
        tick(); rst = 1'b0;

        // Write to 0x04, ready in the first REQUEST cycle.
        setup(16'h0004, 1'b1, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk); check("wr_c0_pready", 64'(b_pready), 64'd0);
        tick(); penable = 1'b1; regs(2'b01, 2'b01, 4'h0, 64'h0);
        @(negedge clk);
        check("wr_c1_valid",   64'(b_valid),   64'd1);
        check("wr_c1_access",  64'(b_access),  64'h3);
        check("wr_c1_address", 64'(b_address), 64'h04);
        check("wr_c1_wdata",   64'(b_wdata),   64'hDEAD_BEEF);
        check("wr_c1_strobe",  64'(b_strobe),  64'hF);
        tick(); regs(2'b00, 2'b00, 4'h0, 64'h0);
        @(negedge clk);
        check("wr_c2_valid",  64'(b_valid),  64'd0);
        check("wr_c2_pready", 64'(b_pready), 64'd0);
        tick(); @(negedge clk);
        check("wr_c3_pready",  64'(b_pready),  64'd1);
        check("wr_c3_pslverr", 64'(b_pslverr), 64'd0);
        check("wr_c3_prdata",  64'(b_prdata),  64'd0);
        release_bus(); @(negedge clk);
        check("wr_c4_pready", 64'(b_pready), 64'd0);

        // Read from register 1, ready two cycles late.
        setup(16'h0108, 1'b0, 32'h0000_0055, 4'h0);
        tick(); penable = 1'b1; regs(2'b10, 2'b00, 4'h0, {32'h1234_5678, 32'hFFFF_0000});
        @(negedge clk);
        check("rd_c1_valid",   64'(a_valid),   64'd1);
        check("rd_c1_access",  64'(a_access),  64'h2);
        check("rd_c1_address", 64'(a_address), 64'h08);
        check("rd_c1_wdata",   64'(a_wdata),   64'd0);
        check("rd_c1_strobe",  64'(a_strobe),  64'hF);
        tick(); @(negedge clk);
        check("rd_c2_valid",  64'(a_valid),  64'd1);
        check("rd_c2_pready", 64'(a_pready), 64'd0);
        tick(); regs(2'b10, 2'b10, 4'h0, {32'h1234_5678, 32'hFFFF_0000});
        @(negedge clk);
        check("rd_c3_pready", 64'(a_pready), 64'd0);
        tick(); regs(2'b00, 2'b00, 4'h0, 64'h0);
        @(negedge clk);
        check("rd_c4_valid",  64'(a_valid),  64'd0);
        check("rd_c4_pready", 64'(a_pready), 64'd0);
        tick(); @(negedge clk);
        check("rd_c5_pready",  64'(a_pready),  64'd1);
        check("rd_c5_prdata",  64'(a_prdata),  64'h1234_5678);
        check("rd_c5_pslverr", 64'(a_pslverr), 64'd0);
        release_bus(); @(negedge clk);
        check("rd_c6_pready", 64'(a_pready), 64'd0);
        check("rd_c6_prdata", 64'(a_prdata), 64'd0);

        // Unmapped read: no register active.
        setup(16'h0110, 1'b0, 32'h0, 4'h0);
        tick(); penable = 1'b1;
        tick(); tick(); @(negedge clk);
        check("um_a_pready",  64'(a_pready),  64'd1);
        check("um_a_prdata",  64'(a_prdata),  64'h0BAD);
        check("um_a_pslverr", 64'(a_pslverr), 64'd1);
        check("um_b_pready",  64'(b_pready),  64'd1);
        check("um_b_prdata",  64'(b_prdata),  64'h0BAD);
        check("um_b_pslverr", 64'(b_pslverr), 64'd0);
        release_bus();

        // Pre-decode miss at 0x140; dut_b keeps waiting and is then aborted.
        setup(16'h0140, 1'b0, 32'h0, 4'h0);
        tick(); penable = 1'b1; regs(2'b01, 2'b00, 4'h0, 64'h0);
        @(negedge clk); check("pd_c1_valid", 64'(a_valid), 64'd0);
        tick(); regs(2'b00, 2'b00, 4'h0, 64'h0);
        @(negedge clk); check("pd_c2_valid", 64'(a_valid), 64'd0);
        tick(); @(negedge clk);
        check("pd_c3_pready",  64'(a_pready),  64'd1);
        check("pd_c3_prdata",  64'(a_prdata),  64'h0BAD);
        check("pd_c3_pslverr", 64'(a_pslverr), 64'd1);
        release_bus(); @(negedge clk);
        check("abort_b_pready", 64'(b_pready), 64'd0);
        check("abort_b_prdata", 64'(b_prdata), 64'd0);

        // Reset in the middle of REQUEST.
        setup(16'h0104, 1'b0, 32'h0, 4'h0);
        tick(); penable = 1'b1; regs(2'b01, 2'b00, 4'h0, 64'h0);
        @(negedge clk); check("rs_c1_valid", 64'(a_valid), 64'd1);
        tick(); rst = 1'b1;
        @(negedge clk); check("rs_c2_valid", 64'(a_valid), 64'd1);
        tick(); rst = 1'b0; psel = 1'b0; penable = 1'b0; regs(2'b00, 2'b00, 4'h0, 64'h0);
        @(negedge clk);
        check("rs_valid",   64'(a_valid),   64'd0);
        check("rs_access",  64'(a_access),  64'd0);
        check("rs_address", 64'(a_address), 64'd0);
        check("rs_strobe",  64'(a_strobe),  64'd0);
        check("rs_pready",  64'(a_pready),  64'd0);
        tick(); @(negedge clk); check("rs_c4_pready", 64'(a_pready), 64'd0);
        tick(); @(negedge clk); check("rs_c5_pready", 64'(a_pready), 64'd0);

        // Normal read after reset; register 1 not ready so its slice must not leak in.
        setup(16'h0104, 1'b0, 32'h0, 4'h0);
        tick(); penable = 1'b1; regs(2'b01, 2'b01, 4'b1100, {32'h1111_1111, 32'hCAFE_F00D});
        tick(); regs(2'b00, 2'b00, 4'h0, 64'h0);
        tick(); @(negedge clk);
        check("ar_pready",  64'(a_pready),  64'd1);
        check("ar_prdata",  64'(a_prdata),  64'hCAFE_F00D);
        check("ar_pslverr", 64'(a_pslverr), 64'd0);
        release_bus();

        // Write answered with SLAVE_ERROR; a setup during RESPOND must be ignored.
        setup(16'h010C, 1'b1, 32'h0000_ABCD, 4'h3);
        tick(); penable = 1'b1; regs(2'b01, 2'b01, 4'b0010, {32'h0, 32'hCAFE_F00D});
        @(negedge clk);
        check("se_access",  64'(a_access),  64'h3);
        check("se_address", 64'(a_address), 64'h0C);
        check("se_wdata",   64'(a_wdata),   64'h0000_ABCD);
        check("se_strobe",  64'(a_strobe),  64'h3);
        tick(); regs(2'b00, 2'b00, 4'h0, 64'h0);
        tick(); penable = 1'b0; paddr = 16'h0100; pwrite = 1'b0;
        @(negedge clk);
        check("se_pready",  64'(a_pready),  64'd1);
        check("se_pslverr", 64'(a_pslverr), 64'd1);
        check("se_prdata",  64'(a_prdata),  64'd0);
        release_bus(); @(negedge clk);
        check("ign_valid",   64'(a_valid),   64'd0);
        check("ign_pready",  64'(a_pready),  64'd0);
        check("ign_pslverr", 64'(a_pslverr), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
